dmk_stream_tx: RTL and testbench
================================

# dmk_stream_tx

Serial digital-stream transmitter: produces the dCLK / dDAT / dFM three-wire stream consumed by the board's digital-data receiver, from 12-bit words pulled over a single-cycle valid/ready handshake. Words are sent MSB first and grouped into frames of FRAME_WORDS words, with the dFM marker on the first bit of each frame. Word underruns are filled with FILL_WORD and counted. The block is used as the stream source on the test/stimulus board and as the loopback generator for receiver bring-up. It runs in the clk80 domain.

## Interface
- CLK_DIV, 20: clk cycles per dCLK half-period (min 2); one bit slot is 2*CLK_DIV cycles.
- WORD_BITS, 12: bits per word.
- FRAME_WORDS, 32: words per frame (min 1).
- FILL_WORD, 12'd0: word sent when no word is transferred at the load point.
- clk  in  1  system clock (clk80); the block's only clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  stream enable, level.
- wordData  in  WORD_BITS  next word to send.
- wordValid  in  1  wordData is valid.
- wordReady  out  1  registered one-cycle load strobe; a transfer occurs when wordReady && wordValid.
- dCLK  out  1  bit clock.
- dDAT  out  1  serial data, MSB first.
- dFM  out  1  frame marker.
- frameStart  out  1  one-cycle pulse at the slot start of bit 0 of word 0.
- busy  out  1  high from leaving IDLE until the return to IDLE.
- underrunCount  out  8  number of fill words sent; saturates at 255.

## Operation
- States: IDLE, LOAD, SHIFT.
- IDLE: dCLK=0, dDAT=0, dFM=0, divider held at 0.
  - When en is sampled high, go to LOAD.
- LOAD: lasts one cycle and asserts wordReady.
  - Next cycle: first slot start of word 0, state becomes SHIFT.
- SHIFT timing within a slot (divider counts 0..2*CLK_DIV-1):
  - Slot start (count 0): dCLK=0; dDAT and dFM are updated.
  - dCLK rises at count CLK_DIV.
  - The next slot start drives dCLK low again.
  - The receiver samples on the dCLK rising edge.
- Word load:
  - wordReady is asserted in the last cycle (count 2*CLK_DIV-1) of bit WORD_BITS-1 of every word that has a successor.
  - On transfer, the shift register loads wordData.
  - With no transfer, the shift register loads FILL_WORD and underrunCount increments (saturating).
- Frame bookkeeping:
  - bitCnt counts 0..WORD_BITS-1; wordCnt counts 0..FRAME_WORDS-1 and wraps.
  - dFM=1 only during the slot of bit 0, word 0; frameStart pulses at that slot start.
- Disable: en low mid-frame does not truncate the frame. The block finishes the last bit of word FRAME_WORDS-1, issues no further wordReady, and returns to IDLE at what would have been the next slot start.
  - If en is still high at the end of the frame, streaming continues seamlessly: the next word is word 0 and dFM=1.
- Reset mid-frame: all state and outputs take their reset values immediately. A word presented at that moment is not transferred.

## Timing
- Reset values: dCLK=0, dDAT=0, dFM=0, wordReady=0, frameStart=0, busy=0, underrunCount=0, state IDLE.
- en sampled high at cycle t:
  - wordReady=1 at t+1.
  - At t+2: dDAT=MSB, dFM=1, frameStart=1, busy=1.
  - dCLK rises at t+2+CLK_DIV.
- Word period is WORD_BITS*2*CLK_DIV cycles. Frame period is FRAME_WORDS times that; there is no gap between frames while en is high.
- Handshake:
  - The source must hold wordValid/wordData stable in the wordReady cycle only.
  - wordValid outside wordReady cycles is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package dmk_pkg holds:
  - the WORD_BITS default and FILL_WORD default;
  - the state enum (IDLE, LOAD, SHIFT);
  - the frame-marker polarity constant.
- Sub-module dmk_bit_timer contains the divider. It emits three strobes: slotStart, riseEdge, and preSlot (the last cycle of a slot). The top holds the FSM, shift register, counters, and underrun counter.

## Test plan
All scenarios use CLK_DIV=2, WORD_BITS=12, FRAME_WORDS=4.
- Reset, then en=1 at cycle 10: wordReady at 11; at 12 dFM=1 and frameStart=1; dCLK rises at 14 and falls at 16; dFM=0 from 16.
- Source always valid with words 12'hA5C, 12'h3F0, 12'h001, 12'hFFF: a decoder sampling dDAT on dCLK rising edges recovers the four words MSB first. The next frame's dFM follows with no gap: 48 slots = 192 cycles.
- wordValid low at the load point for word 2: 12'h000 is sent and underrunCount=1. Force 300 misses: underrunCount=255 and holds.
- Drop en during word 1: words 1..3 complete, no wordReady after word 3, then IDLE with dCLK=0, dDAT=0, busy=0.
- Assert reset mid-word 2: outputs are 0 in the same cycle, underrunCount=0. After release with en=1, a new frame starts with dFM=1.
- Toggle wordValid on non-wordReady cycles with garbage data: transmitted words are unaffected.

Source files
------------

// File: rtl/dmk_pkg.sv
// Shared definitions for the dCLK/dDAT/dFM stream transmitter.
// Holds the word-width and fill-word defaults, the FSM state type and the
// frame-marker polarity.
package dmk_pkg;

    localparam int unsigned                 WORD_BITS_DEF = 12;
    localparam logic [WORD_BITS_DEF-1:0]    FILL_WORD_DEF = '0;

    // Level driven on dFM during the first bit of a frame, and its idle level.
    localparam logic FM_ACTIVE = 1'b1;
    localparam logic FM_IDLE   = ~FM_ACTIVE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_e;

endpackage

// File: rtl/dmk_bit_timer.sv
// Bit-slot divider for the stream transmitter.
// A slot is 2*CLK_DIV clk cycles. The counter runs one cycle ahead of the
// slot position so that the strobes describe the *coming* cycle, which lets
// the top register its outputs directly on them.
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   run_i        in   count while high, held at 0 while low
//   slotStart_c  out  next cycle is slot position 0 (dCLK low, data update)
//   riseEdge_c   out  next cycle is slot position CLK_DIV (dCLK high)
//   preSlot_c    out  next cycle is the last cycle of the slot
module dmk_bit_timer #(
    parameter int unsigned CLK_DIV = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    output logic slotStart_c,
    output logic riseEdge_c,
    output logic preSlot_c
);

    localparam int unsigned SLOT = 2 * CLK_DIV;
    localparam int unsigned CW   = $clog2(SLOT);

    logic [CW-1:0] lead_q;

    // Position of the next cycle within the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lead_q <= '0;
        end else if (!run_i) begin
            lead_q <= '0;
        end else if (lead_q == CW'(SLOT - 1)) begin
            lead_q <= '0;
        end else begin
            lead_q <= lead_q + CW'(1);
        end
    end

    assign slotStart_c = run_i && (lead_q == '0);
    assign riseEdge_c  = run_i && (lead_q == CW'(CLK_DIV));
    assign preSlot_c   = run_i && (lead_q == CW'(SLOT - 1));

endmodule

// File: rtl/dmk_stream_tx.sv
// Serial digital-stream transmitter (clk80 domain).
// Pulls WORD_BITS-bit words over a one-cycle wordReady/wordValid handshake and
// sends them MSB first on dDAT with bit clock dCLK, in frames of FRAME_WORDS
// words marked by dFM on the first bit. Missing words are replaced by
// FILL_WORD and counted in a saturating underrun counter.
//   clk, reset     clock, asynchronous active-high reset
//   en             stream enable (level); frames are never truncated
//   wordData/Valid word source, sampled only in wordReady cycles
//   wordReady      one-cycle load strobe
//   dCLK/dDAT/dFM  serial stream outputs
//   frameStart     pulse at the start of bit 0 of word 0
//   busy           high while not idle
//   underrunCount  fill words sent, saturating at 255
module dmk_stream_tx
    import dmk_pkg::*;
#(
    parameter int unsigned          CLK_DIV     = 20,
    parameter int unsigned          WORD_BITS   = WORD_BITS_DEF,
    parameter int unsigned          FRAME_WORDS = 32,
    parameter logic [WORD_BITS-1:0] FILL_WORD   = WORD_BITS'(FILL_WORD_DEF)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WORD_BITS-1:0] wordData,
    input  logic                 wordValid,
    output logic                 wordReady,
    output logic                 dCLK,
    output logic                 dDAT,
    output logic                 dFM,
    output logic                 frameStart,
    output logic                 busy,
    output logic [7:0]           underrunCount
);

    localparam int unsigned     BW        = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned     FW        = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [BW-1:0]   LAST_BIT  = BW'(WORD_BITS - 1);
    localparam logic [FW-1:0]   LAST_WORD = FW'(FRAME_WORDS - 1);

    state_e                 state_q;
    logic [WORD_BITS-1:0]   shreg_q;
    logic [BW-1:0]          bit_q;
    logic [FW-1:0]          word_q;
    logic                   dclk_q, ddat_q, dfm_q, ready_q, fstart_q, busy_q;
    logic [7:0]             urun_q;

    logic                   slot_start_c, rise_edge_c, pre_slot_c;
    logic                   shifting_c, xfer_c, start_word_c;
    logic [WORD_BITS-1:0]   next_word_c;
    logic [FW-1:0]          word_nxt_c;

    dmk_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .run_i       (state_q != ST_IDLE),
        .slotStart_c (slot_start_c),
        .riseEdge_c  (rise_edge_c),
        .preSlot_c   (pre_slot_c)
    );

    assign shifting_c  = (state_q == ST_SHIFT);
    assign xfer_c      = ready_q && wordValid;
    assign next_word_c = xfer_c ? wordData : FILL_WORD;
    // A new word begins after LOAD, or at the slot boundary ending a word that
    // was granted a successor (its wordReady is still high in that cycle).
    assign start_word_c = (state_q == ST_LOAD)
                       || (shifting_c && slot_start_c && (bit_q == LAST_BIT) && ready_q);
    assign word_nxt_c  = ((state_q == ST_LOAD) || (word_q == LAST_WORD)) ? '0 : word_q + FW'(1);

    // Transmit FSM, shift register, frame counters and underrun counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bit_q    <= '0;
            word_q   <= '0;
            dclk_q   <= 1'b0;
            ddat_q   <= 1'b0;
            dfm_q    <= FM_IDLE;
            ready_q  <= 1'b0;
            fstart_q <= 1'b0;
            busy_q   <= 1'b0;
            urun_q   <= '0;
        end else begin
            ready_q  <= 1'b0;
            fstart_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q <= ST_LOAD;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD, ST_SHIFT: begin
                    if (shifting_c && rise_edge_c) begin
                        dclk_q <= 1'b1;
                    end
                    // Successor decision: always inside a frame, only with en at its end.
                    if (shifting_c && pre_slot_c && (bit_q == LAST_BIT)
                        && ((word_q != LAST_WORD) || en)) begin
                        ready_q <= 1'b1;
                    end
                    if (start_word_c) begin
                        state_q <= ST_SHIFT;
                        shreg_q <= next_word_c;
                        ddat_q  <= next_word_c[WORD_BITS-1];
                        dclk_q  <= 1'b0;
                        bit_q   <= '0;
                        word_q  <= word_nxt_c;
                        if (word_nxt_c == '0) begin
                            dfm_q    <= FM_ACTIVE;
                            fstart_q <= 1'b1;
                        end else begin
                            dfm_q    <= FM_IDLE;
                        end
                        if (!xfer_c && (urun_q != 8'hFF)) begin
                            urun_q <= urun_q + 8'd1;
                        end
                    end else if (shifting_c && slot_start_c) begin
                        dclk_q <= 1'b0;
                        dfm_q  <= FM_IDLE;
                        if (bit_q == LAST_BIT) begin
                            // Frame ended without a successor: back to idle.
                            state_q <= ST_IDLE;
                            ddat_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            bit_q   <= '0;
                            word_q  <= '0;
                            shreg_q <= '0;
                        end else begin
                            bit_q   <= bit_q + BW'(1);
                            shreg_q <= {shreg_q[WORD_BITS-2:0], 1'b0};
                            ddat_q  <= shreg_q[WORD_BITS-2];
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wordReady     = ready_q;
    assign dCLK          = dclk_q;
    assign dDAT          = ddat_q;
    assign dFM           = dfm_q;
    assign frameStart    = fstart_q;
    assign busy          = busy_q;
    assign underrunCount = urun_q;

endmodule

// File: tb/tb_dmk_stream_tx.sv
// Self-checking bench for dmk_stream_tx (CLK_DIV=2, WORD_BITS=12, FRAME_WORDS=4).
// A source process answers wordReady strobes and records the word each strobe
// must produce; a decoder recovers words from dDAT on dCLK rising edges.
module tb_dmk_stream_tx;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned WB      = 12;
    localparam int unsigned FW      = 4;
    localparam int          DEPTH   = 1024;
    localparam logic [WB-1:0] FILL  = 12'h000;

    localparam int M_VALID    = 0;
    localparam int M_GARBAGE  = 1;
    localparam int M_RANDOM   = 2;
    localparam int M_MISS_IDX = 3;
    localparam int M_MISS_ALL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [WB-1:0] wordData;
    logic          wordValid;
    logic          wordReady, dCLK, dDAT, dFM, frameStart, busy;
    logic [7:0]    underrunCount;

    int checks = 0;
    int errors = 0;

    int mode     = M_VALID;
    int miss_idx = 0;

    // Source-owned model state
    logic [WB-1:0] first_words [4] = '{12'hA5C, 12'h3F0, 12'h001, 12'hFFF};
    logic [WB-1:0] exp_val [DEPTH];
    logic          exp_fm  [DEPTH];
    int            exp_wr   = 0;
    int            run_idx  = 0;
    int            miss_cnt = 0;
    logic          src_v;
    logic [WB-1:0] src_d;

    // Decoder-owned state
    logic [WB-1:0] got_val [DEPTH];
    logic          got_fm  [DEPTH];
    logic          got_bad [DEPTH];
    int            got_wr  = 0;
    int            dec_n   = 0;
    logic [WB-1:0] dec_sh  = '0;
    logic          dec_fm  = 1'b0;
    logic          dec_bad = 1'b0;

    // Checker-owned read pointers
    int exp_rd = 0;
    int got_rd = 0;
    int n, rdy, base;

    dmk_stream_tx #(
        .CLK_DIV     (CLK_DIV),
        .WORD_BITS   (WB),
        .FRAME_WORDS (FW),
        .FILL_WORD   (FILL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .wordData      (wordData),
        .wordValid     (wordValid),
        .wordReady     (wordReady),
        .dCLK          (dCLK),
        .dDAT          (dDAT),
        .dFM           (dFM),
        .frameStart    (frameStart),
        .busy          (busy),
        .underrunCount (underrunCount)
    );

    always #5 clk = ~clk;

    // Word source: each wordReady strobe yields exactly one transmitted word,
    // the presented word on a transfer or FILL otherwise.
    always @(negedge clk) begin
        if (reset) begin
            miss_cnt  = 0;
            run_idx   = 0;
            wordValid = 1'b0;
            wordData  = '0;
        end else if (wordReady) begin
            case (mode)
                M_VALID, M_GARBAGE: src_v = 1'b1;
                M_RANDOM:           src_v = ($urandom_range(0, 3) != 0);
                M_MISS_IDX:         src_v = (run_idx != miss_idx);
                default:            src_v = 1'b0;
            endcase
            src_d = (mode == M_VALID && run_idx < 4) ? first_words[2'(run_idx)] : WB'($urandom);
            wordValid = src_v;
            wordData  = src_v ? src_d : WB'($urandom);
            if (exp_wr < DEPTH) begin
                exp_val[exp_wr] = src_v ? src_d : FILL;
                exp_fm[exp_wr]  = ((run_idx % FW) == 0);
                exp_wr++;
            end
            if (!src_v) miss_cnt++;
            run_idx++;
        end else begin
            if (!busy) run_idx = 0;
            wordValid = (mode == M_GARBAGE) ? 1'($urandom_range(0, 1)) : 1'b0;
            wordData  = WB'($urandom);
        end
    end

    // Stream decoder: receiver view, sampling on dCLK rising edges.
    always @(posedge dCLK or posedge reset) begin
        if (reset) begin
            dec_n   = 0;
            dec_sh  = '0;
            dec_bad = 1'b0;
        end else begin
            if (dec_n == 0) dec_fm = dFM;
            else if (dFM) dec_bad = 1'b1;
            dec_sh = {dec_sh[WB-2:0], dDAT};
            dec_n++;
            if (dec_n == int'(WB)) begin
                if (got_wr < DEPTH) begin
                    got_val[got_wr] = dec_sh;
                    got_fm[got_wr]  = dec_fm;
                    got_bad[got_wr] = dec_bad;
                    got_wr++;
                end
                dec_n   = 0;
                dec_bad = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input int bound, output int cnt);
        cnt = 0;
        while (!frameStart && cnt < bound) begin
            step(1);
            cnt++;
        end
        chk("frame_start_seen", 32'(frameStart), 32'd1);
    endtask

    task automatic compare_words();
        int cnt;
        cnt = 0;
        while (got_rd < got_wr) begin
            chk("load_for_word", 32'(exp_wr > exp_rd), 32'd1);
            if (exp_wr <= exp_rd) break;
            chk("word_value", 32'(got_val[got_rd]), 32'(exp_val[exp_rd]));
            chk("word_marker", 32'(got_fm[got_rd]), 32'(exp_fm[exp_rd]));
            chk("marker_extra", 32'(got_bad[got_rd]), 32'd0);
            got_rd++;
            exp_rd++;
            cnt++;
        end
        chk("words_decoded", 32'(cnt > 0), 32'd1);
    endtask

    task automatic chk_underrun_model(input string tag);
        chk(tag, 32'(underrunCount), 32'((miss_cnt > 255) ? 255 : miss_cnt));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_dclk"},  32'(dCLK), 32'd0);
        chk({tag, "_ddat"},  32'(dDAT), 32'd0);
        chk({tag, "_dfm"},   32'(dFM), 32'd0);
        chk({tag, "_ready"}, 32'(wordReady), 32'd0);
        chk({tag, "_fs"},    32'(frameStart), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        mode  = M_VALID;
        step(3);
        chk_quiet("reset");
        chk("reset_underrun", 32'(underrunCount), 32'd0);
        reset = 1'b0;
        step(2);
        chk_quiet("idle");

        // Start-up timing relative to the cycle en is first sampled.
        en = 1'b1;
        step(1);
        chk("t1_ready", 32'(wordReady), 32'd1);
        chk("t1_dfm", 32'(dFM), 32'd0);
        step(1);
        chk("t2_dfm", 32'(dFM), 32'd1);
        chk("t2_fs", 32'(frameStart), 32'd1);
        chk("t2_ddat_msb", 32'(dDAT), 32'd1);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_dclk", 32'(dCLK), 32'd0);
        chk("t2_ready", 32'(wordReady), 32'd0);
        step(1);
        chk("t3_dclk", 32'(dCLK), 32'd0);
        chk("t3_fs", 32'(frameStart), 32'd0);
        step(1);
        chk("t4_dclk_rise", 32'(dCLK), 32'd1);
        chk("t4_dfm", 32'(dFM), 32'd1);
        step(1);
        chk("t5_dclk", 32'(dCLK), 32'd1);
        step(1);
        chk("t6_dclk_fall", 32'(dCLK), 32'd0);
        chk("t6_dfm", 32'(dFM), 32'd0);
        chk("t6_ddat_bit10", 32'(dDAT), 32'd0);

        // Seamless frames: next frame marker exactly 48 slots later.
        wait_fs(400, n);
        chk("frame_period", 32'(n + 4), 32'd192);
        chk("no_underrun", 32'(underrunCount), 32'd0);
        compare_words();

        // Garbage on wordValid/wordData outside wordReady, then drop en in word 1.
        mode = M_GARBAGE;
        wait_fs(400, n);
        step(60);
        en  = 1'b0;
        n   = 60;
        rdy = 0;
        while (busy && n < 400) begin
            step(1);
            n++;
            if (wordReady) rdy++;
        end
        chk("stop_cycle", 32'(n), 32'd192);
        chk("stop_ready_count", 32'(rdy), 32'd2);
        chk_quiet("stopped");
        rdy = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (wordReady || busy) rdy++;
        end
        chk("stays_idle", 32'(rdy), 32'd0);
        compare_words();

        // Fresh run with word 2 missing at its load point.
        reset = 1'b1;
        step(2);
        exp_rd = exp_wr;
        got_rd = got_wr;
        base   = got_wr;
        mode     = M_MISS_IDX;
        miss_idx = 2;
        reset = 1'b0;
        step(1);
        en = 1'b1;
        step(150);
        chk("underrun_one", 32'(underrunCount), 32'd1);
        chk_underrun_model("underrun_one_model");
        chk("fill_word_sent", 32'(got_val[base + 2]), 32'(FILL));
        compare_words();

        // Reset in the middle of word 2 of the following frame.
        step(164);
        compare_words();
        reset = 1'b1;
        #1;
        chk_quiet("midreset");
        chk("midreset_underrun", 32'(underrunCount), 32'd0);
        step(1);
        exp_rd = exp_wr;
        got_rd = got_wr;
        mode   = M_RANDOM;
        reset  = 1'b0;
        wait_fs(50, n);
        chk("restart_latency", 32'(n), 32'd2);
        chk("restart_dfm", 32'(dFM), 32'd1);

        // Random word availability over two frames.
        step(384);
        compare_words();
        chk_underrun_model("underrun_random_model");

        // Persistent starvation: counter saturates and holds.
        mode = M_MISS_ALL;
        step(300 * 48);
        chk("underrun_sat", 32'(underrunCount), 32'd255);
        chk_underrun_model("underrun_sat_model");
        step(200);
        chk("underrun_hold", 32'(underrunCount), 32'd255);
        compare_words();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
